// File: rtl/fifo_pkg.sv
// Shared types and helpers for the read-side FIFO drain/packer.
package fifo_pkg;

  typedef enum logic [1:0] {StFill, StDrain, StEmit, StDone} rd_pack_state_t;

  // Width able to hold any count from 0 to pack inclusive.
  function automatic int unsigned cnt_w(input int unsigned pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word output stream of the read-side packer (valid/ready).
interface fifo_rd_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4
);
  localparam int unsigned CNT_W = fifo_pkg::cnt_w(PACK);

  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [CNT_W-1:0]           out_bytes;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;

  modport master (output out_data, out_bytes, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_bytes, out_last, out_valid, output out_ready);

endinterface

// File: rtl/rd_pack_accum.sv
// Lane-write accumulator: bytes fill lanes in arrival order; clear zeroes every lane so a
// partial word is naturally zero-padded.
module rd_pack_accum #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       clear,
  output logic [DATA_WIDTH*PACK-1:0] acc_word,
  output logic [CNT_W-1:0]           acc_cnt
);

  logic [PACK-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  // A byte written in the clear cycle becomes lane 0 of the next word.
  always_comb begin
    lanes_d = clear ? '0 : lanes_q;
    cnt_d   = clear ? '0 : cnt_q;
    if (wr_en) begin
      for (int unsigned i = 0; i < PACK; i++) begin
        if (cnt_d == CNT_W'(i)) lanes_d[i] = wr_data;
      end
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_word = lanes_q;
  assign acc_cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain drain stage: pops the async FIFO, packs PACK entries per output word and, on
// flush, emits the zero-padded partial word marked last.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  flush_done,
  fifo_rd_packer_if.master      out_if
);

  localparam int unsigned      CNT_W   = cnt_w(PACK);
  localparam logic [CNT_W-1:0] PackCnt = CNT_W'(PACK);
  localparam logic [CNT_W:0]   PackSum = (CNT_W + 1)'(PACK);

  rd_pack_state_t             state_q;
  logic [CNT_W-1:0]           inflight_q;
  logic [CNT_W-1:0]           acc_cnt;
  logic [DATA_WIDTH*PACK-1:0] acc_word;
  logic [CNT_W:0]             slot_sum, slot_eff;
  logic                       out_free, landing, move_full, load_part;

  assign out_free = !out_if.out_valid || out_if.out_ready;
  assign landing  = (inflight_q != '0);

  // In DRAIN a full word still leaves normally when a byte popped in the flush cycle lands.
  assign move_full = (acc_cnt == PackCnt) && out_free &&
                     ((state_q == StFill) || ((state_q == StDrain) && landing));
  assign load_part = (state_q == StDrain) && !landing && (acc_cnt != '0) && out_free;

  assign slot_sum = {1'b0, acc_cnt} + {1'b0, inflight_q};
  assign slot_eff = move_full ? slot_sum - PackSum : slot_sum;

  // Taking the last slot needs a free out register now: it then stays free for the landing
  // cycle, where the full word moves out and the landing byte starts the next one.
  assign rinc = !rrst && !rempty && (state_q == StFill) &&
                ((slot_eff < PackSum) || ((slot_eff == PackSum) && out_free));

  rd_pack_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .PACK      (PACK),
    .CNT_W     (CNT_W)
  ) u_accum (
    .rclk    (rclk),
    .rrst    (rrst),
    .wr_en   (landing),
    .wr_data (rdata),
    .clear   (move_full || load_part),
    .acc_word(acc_word),
    .acc_cnt (acc_cnt)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q          <= StFill;
      inflight_q       <= '0;
      flush_done       <= 1'b0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_bytes <= '0;
      out_if.out_last  <= 1'b0;
    end else begin
      inflight_q <= CNT_W'(rinc);
      flush_done <= 1'b0;
      if (out_if.out_valid && out_if.out_ready) out_if.out_valid <= 1'b0;
      if (move_full || load_part) begin
        out_if.out_data  <= acc_word;
        out_if.out_bytes <= acc_cnt;
        out_if.out_last  <= load_part;
        out_if.out_valid <= 1'b1;
      end
      case (state_q)
        StFill:  if (flush) state_q <= StDrain;
        StDrain: begin
          if (!landing) begin
            if (acc_cnt == '0) begin
              state_q    <= StDone;
              flush_done <= 1'b1;
            end else if (out_free) begin
              state_q <= StEmit;
            end
          end
        end
        StEmit: begin
          if (out_if.out_valid && out_if.out_ready) begin
            state_q    <= StDone;
            flush_done <= 1'b1;
          end
        end
        StDone:  state_q <= StFill;
        default: state_q <= StFill;
      endcase
    end
  end

  // A byte may land into a full accumulator only in the cycle that word leaves.
  a_no_overfill: assert property (@(posedge rclk) disable iff (rrst) slot_eff <= PackSum);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO source model, word-grouping reference model and
// directed scenarios with literal expectations.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned CW = $clog2(PK + 1);

  typedef struct packed {
    logic [DW*PK-1:0] data;
    logic [CW-1:0]    bytes;
    logic             last;
  } word_t;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rinc;
  logic          flush = 1'b0;
  logic          flush_done;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) out_if ();

  fifo_rd_packer #(
    .DATA_WIDTH(DW),
    .PACK      (PK)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .flush_done(flush_done),
    .out_if    (out_if)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input logic [DW*PK-1:0] d, input int b, input logic l);
    word_t w;
    w.data  = d;
    w.bytes = CW'(b);
    w.last  = l;
    return w;
  endfunction

  // Source FIFO contents, reference model state and observations.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] cur_q[$];
  word_t         exp_q[$];
  word_t         got_q[$];
  logic          pend_valid = 1'b0;
  logic [DW-1:0] pend_byte = '0;
  logic          prev_stall = 1'b0;
  word_t         prev_w = '0;
  int cyc = 0, n_pops = 0, hs_cyc = 0, fd_cyc = 0, fl_cyc = 0, run = 0, max_run = 0;

  // Stimulus-side knobs read by the FIFO/consumer driver.
  logic ready_set = 1'b0, rand_ready = 1'b0, toggle_en = 1'b0, tog = 1'b0;

  function automatic word_t got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '0;
  endfunction

  function automatic word_t close_group(input logic last);
    word_t w;
    w = '0;
    for (int i = 0; i < cur_q.size(); i++) w.data[i*DW +: DW] = cur_q[i];
    w.bytes = CW'(cur_q.size());
    w.last  = last;
    return w;
  endfunction

  // FIFO read port and consumer: rdata follows an accepted pop by one cycle; rempty is
  // recomputed once per cycle, so it is pessimistic like a registered flag.
  always @(posedge rclk) begin
    #2;
    if (pend_valid) rdata = pend_byte;
    tog    = toggle_en ? ~tog : 1'b0;
    rempty = tog | (src_q.size() == 0);
    out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_set;
  end

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge rclk) begin
    word_t w;
    cyc++;
    w = {out_if.out_data, out_if.out_bytes, out_if.out_last};
    if (rrst) begin
      chk("reset_rinc", rinc, 0);
      chk("reset_valid", out_if.out_valid, 0);
      chk("reset_word", w, 0);
      chk("reset_flush_done", flush_done, 0);
      cur_q.delete();
      exp_q.delete();
      pend_valid = 1'b0;
      prev_stall = 1'b0;
      run = 0;
    end else begin
      chk("rinc_while_empty", rinc & rempty, 0);
      if (prev_stall) begin
        chk("hold_valid", out_if.out_valid, 1);
        chk("hold_word", w, prev_w);
      end
      if (out_if.out_valid && out_if.out_ready) begin
        hs_cyc = cyc;
        got_q.push_back(w);
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("word", w, exp_q.pop_front());
      end
      if (flush_done) fd_cyc = cyc;
      run     = rinc ? run + 1 : 0;
      max_run = (run > max_run) ? run : max_run;
      pend_valid = rinc;
      if (rinc) begin
        n_pops++;
        pend_byte = (src_q.size() != 0) ? src_q.pop_front() : 8'hEE;
        cur_q.push_back(pend_byte);
        if (cur_q.size() == PK) begin
          exp_q.push_back(close_group(1'b0));
          cur_q.delete();
        end
      end
      if (flush) begin
        fl_cyc = cyc;
        if (cur_q.size() != 0) begin
          exp_q.push_back(close_group(1'b1));
          cur_q.delete();
        end
      end
      prev_stall = out_if.out_valid & !out_if.out_ready;
      prev_w     = w;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      idle(1);
      k++;
    end
    chk(name, got_q.size() >= n, 1);
  endtask

  task automatic pulse_flush_wait(input int budget, input string name);
    int k = 0;
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    while (fd_cyc <= fl_cyc && k < budget) begin
      idle(1);
      k++;
    end
    chk(name, fd_cyc > fl_cyc, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, base;
    idle(3);
    rrst = 1'b0;

    // Back-to-back words with a ready consumer.
    ready_set = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    wait_got(2, 60, "t1_words");
    chk("t1_word0", got_at(0), mk(32'h04030201, 4, 1'b0));
    chk("t1_word1", got_at(1), mk(32'h08070605, 4, 1'b0));
    chk("t1_rinc_run", max_run, 8);

    // Stalled consumer: one word held, one word buffered, then popping stops.
    ready_set = 1'b0;
    idle(2);
    g    = got_q.size();
    base = n_pops;
    for (int i = 1; i <= 12; i++) src_q.push_back(8'(i));
    idle(20);
    chk("t2_pops_stalled", n_pops - base, 8);
    chk("t2_rinc_low", rinc, 0);
    chk("t2_valid_held", out_if.out_valid, 1);
    chk("t2_data_held", out_if.out_data, 32'h04030201);
    ready_set = 1'b1;
    wait_got(g + 3, 60, "t2_words");
    chk("t2_word0", got_at(g), mk(32'h04030201, 4, 1'b0));
    chk("t2_word1", got_at(g + 1), mk(32'h08070605, 4, 1'b0));
    chk("t2_word2", got_at(g + 2), mk(32'h0C0B0A09, 4, 1'b0));

    // Flush of a three-byte partial word.
    idle(3);
    g = got_q.size();
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    src_q.push_back(8'hCC);
    idle(8);
    pulse_flush_wait(30, "t3_flush_done_seen");
    chk("t3_word", got_at(g), mk(32'h00CCBBAA, 3, 1'b1));
    chk("t3_done_after_hs", fd_cyc - hs_cyc, 1);

    // Flush with nothing buffered: no word, done two cycles after the flush cycle.
    idle(3);
    g = got_q.size();
    pulse_flush_wait(30, "t4_flush_done_seen");
    chk("t4_done_latency", fd_cyc - fl_cyc, 2);
    idle(3);
    chk("t4_no_word", got_q.size(), g);

    // Toggling empty flag and random consumer over 1000 bytes.
    g    = got_q.size();
    base = n_pops;
    toggle_en  = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom));
    wait_got(g + 250, 20000, "t5_words");
    toggle_en  = 1'b0;
    rand_ready = 1'b0;
    ready_set  = 1'b1;
    idle(5);
    chk("t5_pops", n_pops - base, 1000);
    chk("t5_model_drained", exp_q.size(), 0);

    // Reset with a held word and two accumulated bytes, then a clean word.
    ready_set = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h51 + i));
    idle(15);
    chk("t6_valid_before", out_if.out_valid, 1);
    chk("t6_data_before", out_if.out_data, 32'h54535251);
    g = got_q.size();
    rrst = 1'b1;
    #1;
    chk("t6_rst_valid", out_if.out_valid, 0);
    chk("t6_rst_data", out_if.out_data, 0);
    chk("t6_rst_bytes", out_if.out_bytes, 0);
    chk("t6_rst_rinc", rinc, 0);
    idle(2);
    rrst = 1'b0;
    ready_set = 1'b1;
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    src_q.push_back(8'h44);
    wait_got(g + 1, 40, "t6_words");
    chk("t6_word", got_at(g), mk(32'h44332211, 4, 1'b0));
    idle(3);
    chk("t6_word_count", got_q.size(), g + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
